// File: rtl/cipher_pkg.sv
// Shared cipher definitions for the 8-bit cipher link (transmit side, receive side, bench).
// Also holds the receive state type. That type gains RX_PARITY when CIPHER_RX_PARITY_EN is defined.
package cipher_pkg;

  localparam int unsigned CIPHER_ROT = 3;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef CIPHER_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  // c = rotl(p ^ key, CIPHER_ROT)
  function automatic logic [7:0] cipher_encrypt(input logic [7:0] p, input logic [7:0] key);
    logic [7:0] x;
    x = p ^ key;
    return (x << CIPHER_ROT) | (x >> (8 - CIPHER_ROT));
  endfunction

  // p = rotr(c, CIPHER_ROT) ^ key
  function automatic logic [7:0] cipher_decrypt(input logic [7:0] c, input logic [7:0] key);
    logic [7:0] r;
    r = (c >> CIPHER_ROT) | (c << (8 - CIPHER_ROT));
    return r ^ key;
  endfunction

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both flops reset to the idle level (1).
module rx_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cipher_uart_rx.sv
// Cipher-link UART receiver: 8N1 deserialiser, decrypt, and a one-entry valid/ready holding register.
// Define CIPHER_RX_PARITY_EN to add an even-parity bit after the data bits.
module cipher_uart_rx
  import cipher_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  input  logic [7:0] key,
  input  logic       dec_en,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t   state;
  logic        rx_s;
  logic        rx_prev;
  logic [1:0]  sync_ok;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  plain;
  logic        fall;
  logic        bit_tick;
  logic        half_tick;

  rx_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_i),
    .q     (rx_s)
  );

  always_comb begin
    plain     = dec_en ? cipher_decrypt(shreg, key) : shreg;
    fall      = rx_prev & ~rx_s;
    bit_tick  = (cnt == BIT_LAST);
    half_tick = (cnt == HALF_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      rx_prev   <= 1'b0;
      sync_ok   <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // The synchroniser's reset value is not a real line level: edge detection
      // is armed only after a genuine high has come through both flops, so a
      // line already low at reset release is ignored.
      sync_ok   <= {sync_ok[0], 1'b1};
      rx_prev   <= sync_ok[1] & rx_s;

      if (out_valid && out_ready)
        out_valid <= 1'b0;

      case (state)
        RX_IDLE: begin
          if (fall) begin
            state   <= RX_START;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end

        RX_START: begin
          if (half_tick) begin
            cnt   <= '0;
            state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RX_DATA: begin
          if (bit_tick) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef CIPHER_RX_PARITY_EN
              state <= RX_PARITY;
`else
              state <= RX_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef CIPHER_RX_PARITY_EN
        RX_PARITY: begin
          if (bit_tick) begin
            cnt <= '0;
            if ((^shreg) == rx_s) begin
              state <= RX_STOP;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        RX_STOP: begin
          if (bit_tick) begin
            cnt   <= '0;
            state <= RX_IDLE;
            // Completion returns to IDLE mid stop bit so back-to-back frames are caught.
            if (rx_s) begin
              if (!out_valid || out_ready) begin
                out_data  <= plain;
                out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_uart_rx.sv
// Directed bench for cipher_uart_rx (default 8N1 build) with a scoreboard of expected output bytes.
module tb_cipher_uart_rx;

  localparam int CPB = 16;
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] key = 8'h5A;
  logic       dec_en = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       frame_err;
  logic       overrun;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int valid_cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int xfer_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] sb[$];

  cipher_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (rx_i),
    .key       (key),
    .dec_en    (dec_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) valid_cyc++;
      if (out_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = out_valid;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $error("FAIL unexpected_xfer: observed %0h expected none", out_data);
        end else begin
          chk("xfer_data", out_data, sb.pop_front());
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic wait_bit();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    rx_i = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_bit();
    end
    rx_i = stop_bit;
    wait_bit();
    rx_i = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, f0, o0, x0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Decrypt 0xD8 with key 0x5A -> 0x41, one valid cycle, documented latency
    v0 = valid_cyc;
    sb.push_back(8'h41);
    send_frame(8'hD8, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("latency", rise_cyc - start_cyc, LAT);
    chk("valid_width", valid_cyc - v0, 1);
    drain("drain_dec");

    // Pass-through
    dec_en = 1'b0;
    sb.push_back(8'hD8);
    send_frame(8'hD8, 1'b1);
    repeat (4) @(posedge clk);
    drain("drain_pass");
    dec_en = 1'b1;

    // Overrun: held byte kept, second byte dropped
    out_ready = 1'b0;
    o0 = ov_cnt;
    x0 = xfer_cnt;
    sb.push_back(8'h41);
    send_frame(8'hD8, 1'b1);
    send_frame(8'h00, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("ovr_held_data", out_data, 8'h41);
    chk("ovr_held_valid", out_valid, 1'b1);
    chk("ovr_pulse", ov_cnt - o0, 1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("ovr_one_xfer", xfer_cnt - x0, 1);
    chk("ovr_valid_clr", out_valid, 1'b0);
    drain("drain_ovr");

    // Stop bit low -> frame error, no output; then a good frame
    f0 = fe_cnt;
    x0 = xfer_cnt;
    send_frame(8'hD8, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("ferr_pulse", fe_cnt - f0, 1);
    chk("ferr_no_xfer", xfer_cnt - x0, 0);
    chk("ferr_valid", out_valid, 1'b0);
    sb.push_back(8'h41);
    send_frame(8'hD8, 1'b1);
    repeat (4) @(posedge clk);
    drain("drain_ferr");

    // Short low glitch -> nothing
    f0 = fe_cnt;
    o0 = ov_cnt;
    x0 = xfer_cnt;
    @(posedge clk);
    #1;
    rx_i = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    chk("glitch_fe", fe_cnt - f0, 0);
    chk("glitch_ov", ov_cnt - o0, 0);
    chk("glitch_xfer", xfer_cnt - x0, 0);

    // Reset during DATA, released with the line still low
    f0 = fe_cnt;
    x0 = xfer_cnt;
    @(posedge clk);
    #1;
    rx_i = 1'b0;
    repeat (3 * CPB + CPB / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6 * CPB) @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (4 * CPB) @(posedge clk);
    #1;
    chk("rstmid_fe", fe_cnt - f0, 0);
    chk("rstmid_xfer", xfer_cnt - x0, 0);
    chk("rstmid_valid", out_valid, 1'b0);
    sb.push_back(8'h41);
    send_frame(8'hD8, 1'b1);
    repeat (4) @(posedge clk);
    drain("drain_rstmid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cipher_uart_rx.md
# cipher_uart_rx

Serial receive end of the 8-bit cipher link. It deserialises an 8N1 UART frame from `rx_i` and decrypts the byte with the shared 8-bit key. The recovered plaintext is presented on a valid/ready output held in a one-entry holding register. It sits between the board's RX pin and any plaintext consumer, and is the counterpart of the encrypting transmit side.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit (12 MHz / 115200). Legal range is 4 or more.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_i`  in  1  asynchronous serial line; idles high.
- `key`  in  8  cipher key; sampled at the stop-bit sample cycle.
- `dec_en`  in  1  1 = decrypt; 0 = pass the received byte through unchanged. Sampled with `key`.
- `out_data`  out  8  plaintext byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts; a transfer occurs when `out_valid && out_ready`.
- `frame_err`  out  1  one-cycle pulse: the stop bit was sampled low.
- `overrun`  out  1  one-cycle pulse: a completed byte was dropped.

## Operation
- Decrypt function: `p = rotr(c, 3) ^ key`. This is the inverse of encrypt `c = rotl(p ^ key, 3)`.
- `rx_i` passes through a 2-flop synchroniser, giving `rx_s`. Both flops reset to 1.
- State machine: IDLE, START, DATA, STOP, and PARITY when configured.
  - IDLE: a falling edge on `rx_s` (previous 1, current 0) moves to START and clears the bit counter.
  - START: after `CLKS_PER_BIT/2` cycles (integer divide), sample `rx_s`. A 0 moves to DATA. A 1 is a glitch: return to IDLE with no flags.
  - DATA: sample every `CLKS_PER_BIT` cycles, LSB first, into an 8-bit shift register. After bit 7, move to STOP (or PARITY).
  - STOP: sample once after `CLKS_PER_BIT` cycles.
    - Sample = 1: the byte completes and the state returns to IDLE in the same cycle. The FSM does not wait for the end of the stop bit, so back-to-back frames are received.
    - Sample = 0: pulse `frame_err`, discard the byte, return to IDLE. A line held low does not re-trigger; a new falling edge is required.
- Holding register:
  - On byte completion, if `!out_valid`, or if `out_valid && out_ready` in that same cycle, load the (decrypted) byte and set `out_valid` on the next edge.
  - If `out_valid && !out_ready` on completion, the held byte is kept, the new byte is dropped, and `overrun` pulses.
  - A transfer with no completion clears `out_valid`.
  - `out_data` is stable while `out_valid && !out_ready`.
- `key`/`dec_en` changes mid-frame have no effect. Only their values at the stop-sample cycle matter.

## Timing
- Reset values: `out_data` = 0x00, `out_valid` = 0, `frame_err` = 0, `overrun` = 0, state IDLE, shift register 0.
- A reset asserted mid-frame aborts the frame with no output and no flags. After release, a line that is already low is ignored until the next falling edge.
- Let T0 be the cycle the falling edge is seen on `rx_s`, which is 2 cycles after `rx_i` falls.
  - Start sample: T0 + `CLKS_PER_BIT/2`.
  - Data bit i sample: T0 + `CLKS_PER_BIT/2` + (i+1)·`CLKS_PER_BIT`.
  - Stop sample: T0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` (10· when parity is enabled).
- `out_valid` rises 1 cycle after the stop sample.
- `frame_err` and `overrun` are high for exactly the 1 cycle after the stop sample.
- Decrypt is combinational into the holding-register D input; it adds no extra cycle.

## Configuration
- Macro: `CIPHER_RX_PARITY_EN`.
- Defined:
  - A PARITY state follows DATA and samples one even-parity bit over the 8 ciphertext bits.
  - On mismatch, the byte is dropped and `frame_err` pulses; the stop bit is not sampled; the FSM returns to IDLE.
- Undefined: the frame is 8N1, the PARITY state does not exist, and the stop sample is at 9·`CLKS_PER_BIT`.

## Structure
- Package `cipher_pkg` holds:
  - `CIPHER_ROT` = 3;
  - functions `cipher_encrypt(p, key)` and `cipher_decrypt(c, key)`;
  - the rx-state enum typedef.
- The transmit side and the bench reuse the package.
- One sub-module: `rx_sync2`, the 2-flop synchroniser with reset-to-1.
- Bit timer, FSM and holding register stay in `cipher_uart_rx`.

## Test plan
- Key 0x5A, `dec_en` = 1, send frame 0xD8, `out_ready` = 1 → `out_data` = 0x41 with `out_valid` for 1 cycle, at the documented latency.
- `dec_en` = 0, send 0xD8 → `out_data` = 0xD8.
- `out_ready` = 0, send 0xD8 then 0x00 back-to-back → `out_data` stays 0x41, `overrun` pulses once. Raising `out_ready` then transfers 0x41 only.
- Send 0xD8 with stop bit low → `frame_err` pulses, `out_valid` stays 0. A following good frame decodes correctly.
- A low glitch of `CLKS_PER_BIT/4` on `rx_i` → no output and no flags.
- Assert `rst_n` low during DATA of a frame, release while the line is still low → no output. The next full frame decodes correctly.
